// File: rtl/l1d_write_buffer.sv
// Posted write buffer between the L1D lower-memory port and main memory, with read forwarding.
// Optional macro WB_COALESCE_EN: writes to an already-buffered address merge into that entry.
module l1d_write_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   up_request,
    input  logic                   up_write_enable,
    input  logic [ADDR_WIDTH-1:0]  up_address,
    input  logic [DATA_WIDTH-1:0]  up_write_data,
    output logic [DATA_WIDTH-1:0]  up_response_data,
    output logic                   up_ready,
    output logic                   dn_request,
    output logic                   dn_write_enable,
    output logic [ADDR_WIDTH-1:0]  dn_address,
    output logic [DATA_WIDTH-1:0]  dn_write_data,
    input  logic [DATA_WIDTH-1:0]  dn_response_data,
    input  logic                   dn_ready,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_full,
    output logic                   wb_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRdMem, StDrain, StResp} state_e;

    state_e                  state_q;
    logic [DEPTH-1:0]        ent_valid_q;
    logic [ADDR_WIDTH-1:0]   ent_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]   ent_data_q [DEPTH];
    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [CW-1:0]           count_q;
    logic                    up_ready_q;
    logic [DATA_WIDTH-1:0]   up_rdata_q;
    logic                    dn_request_q;
    logic                    dn_we_q;
    logic [ADDR_WIDTH-1:0]   dn_addr_q;
    logic [DATA_WIDTH-1:0]   dn_wdata_q;

    logic                    up_new;
    logic                    serving_read;
    logic                    fwd_hit;
    logic [PW-1:0]           fwd_idx;
    logic [PW-1:0]           fwd_scan;
    logic                    wr_alloc;
    logic                    wr_merge;
    logic                    rd_hit;
    logic                    rd_miss;
    logic                    pop;

    assign up_ready         = up_ready_q;
    assign up_response_data = up_rdata_q;
    assign dn_request       = dn_request_q;
    assign dn_write_enable  = dn_we_q;
    assign dn_address       = dn_addr_q;
    assign dn_write_data    = dn_wdata_q;
    assign wb_count         = count_q;
    assign wb_full          = (count_q == CW'(DEPTH));
    assign wb_empty         = (count_q == '0);

    // Scan oldest to youngest so the last match found is the youngest entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_idx  = '0;
        fwd_scan = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_scan = head_q + PW'(i);
            if (ent_valid_q[fwd_scan] && (ent_addr_q[fwd_scan] == up_address)) begin
                fwd_hit = 1'b1;
                fwd_idx = fwd_scan;
            end
        end
    end

    assign up_new       = up_request && !up_ready_q;
    assign serving_read = (state_q == StRdMem) || (state_q == StResp);
    assign rd_hit       = up_new && !up_write_enable && !serving_read && fwd_hit;
    assign rd_miss      = up_new && !up_write_enable && !serving_read && !fwd_hit;
    assign wr_alloc     = up_new && up_write_enable && !wr_merge && !wb_full;
    assign pop          = (state_q == StDrain) && dn_ready;

`ifdef WB_COALESCE_EN
    logic          merge_hit;
    logic [PW-1:0] merge_idx;
    logic [PW-1:0] merge_scan;
    logic          head_busy;

    // The head is also off-limits in the IDLE cycle that launches its drain.
    assign head_busy = (state_q == StDrain) || ((state_q == StIdle) && !wb_empty);

    always_comb begin
        merge_hit  = 1'b0;
        merge_idx  = '0;
        merge_scan = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            merge_scan = head_q + PW'(i);
            if (ent_valid_q[merge_scan] && (ent_addr_q[merge_scan] == up_address) &&
                !(head_busy && (merge_scan == head_q))) begin
                merge_hit = 1'b1;
                merge_idx = merge_scan;
            end
        end
    end

    assign wr_merge = up_new && up_write_enable && merge_hit;
`else
    assign wr_merge = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            ent_addr_q[tail_q] <= up_address;
            ent_data_q[tail_q] <= up_write_data;
        end
`ifdef WB_COALESCE_EN
        if (wr_merge) begin
            ent_data_q[merge_idx] <= up_write_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            ent_valid_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            up_ready_q   <= 1'b0;
            up_rdata_q   <= '0;
            dn_request_q <= 1'b0;
            dn_we_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_wdata_q   <= '0;
        end else begin
            up_ready_q <= 1'b0;

            if (wr_alloc || wr_merge || rd_hit) begin
                up_ready_q <= 1'b1;
            end
            if (rd_hit) begin
                up_rdata_q <= ent_data_q[fwd_idx];
            end
            if (wr_alloc) begin
                ent_valid_q[tail_q] <= 1'b1;
                tail_q              <= tail_q + PW'(1);
            end
            if (pop) begin
                ent_valid_q[head_q] <= 1'b0;
                head_q              <= head_q + PW'(1);
            end

            case ({wr_alloc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            unique case (state_q)
                StIdle: begin
                    if (rd_miss) begin
                        dn_request_q <= 1'b1;
                        dn_we_q      <= 1'b0;
                        dn_addr_q    <= up_address;
                        state_q      <= StRdMem;
                    end else if (!wb_empty) begin
                        dn_request_q <= 1'b1;
                        dn_we_q      <= 1'b1;
                        dn_addr_q    <= ent_addr_q[head_q];
                        dn_wdata_q   <= ent_data_q[head_q];
                        state_q      <= StDrain;
                    end
                end
                StRdMem: begin
                    if (dn_ready) begin
                        dn_request_q <= 1'b0;
                        up_rdata_q   <= dn_response_data;
                        up_ready_q   <= 1'b1;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                StDrain: begin
                    if (dn_ready) begin
                        dn_request_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_l1d_write_buffer.sv
// Scoreboard bench for l1d_write_buffer: expected upstream responses and downstream
// transactions are queued by the stimulus and popped by independent monitors.
module tb_l1d_write_buffer;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } up_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dn_exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        up_request;
    logic        up_write_enable;
    logic [31:0] up_address;
    logic [31:0] up_write_data;
    logic [31:0] up_response_data;
    logic        up_ready;
    logic        dn_request;
    logic        dn_write_enable;
    logic [31:0] dn_address;
    logic [31:0] dn_write_data;
    logic [31:0] dn_response_data;
    logic        dn_ready;
    logic [2:0]  wb_count;
    logic        wb_full;
    logic        wb_empty;

    int          passed = 0;
    int          total = 0;
    int          cyc_n = 0;
    int          up_pulses = 0;
    int          last_up_cyc = 0;
    int          last_rd_cyc = 0;
    int          pop_cyc = 0;
    int          wait_n = 0;
    int          wait_cnt = 0;
    int          lat = 0;
    int          lat5 = 0;
    int          p0 = 0;
    logic        mem_stall;
    int          mem_delay;
    logic [31:0] mem_rdata;
    up_exp_t     exp_up_q[$];
    dn_exp_t     exp_dn_q[$];
    up_exp_t     mon_e;
    dn_exp_t     mem_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    l1d_write_buffer #(
        .DEPTH      (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .up_request       (up_request),
        .up_write_enable  (up_write_enable),
        .up_address       (up_address),
        .up_write_data    (up_write_data),
        .up_response_data (up_response_data),
        .up_ready         (up_ready),
        .dn_request       (dn_request),
        .dn_write_enable  (dn_write_enable),
        .dn_address       (dn_address),
        .dn_write_data    (dn_write_data),
        .dn_response_data (dn_response_data),
        .dn_ready         (dn_ready),
        .wb_count         (wb_count),
        .wb_full          (wb_full),
        .wb_empty         (wb_empty)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic exp_dn(input logic we, input logic [31:0] addr, input logic [31:0] data);
        dn_exp_t e;
        e.we = we;
        e.addr = addr;
        e.data = data;
        exp_dn_q.push_back(e);
    endtask

    task automatic up_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, output int cycles);
        up_exp_t e;
        e.is_read = !we;
        e.data = exp_rdata;
        exp_up_q.push_back(e);
        @(negedge clk);
        up_request = 1'b1;
        up_write_enable = we;
        up_address = addr;
        up_write_data = wdata;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!up_ready && cycles < 200);
        last_up_cyc = cyc_n;
        up_request = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!wb_empty && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, wb_count, 0);
        @(negedge clk);
    endtask

    // Upstream monitor: every up_ready pulse must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (up_ready) begin
                up_pulses++;
                if (exp_up_q.size() == 0) begin
                    total++;
                    $display("FAIL up_unexpected: got up_ready=1 required no pulse");
                end else begin
                    mon_e = exp_up_q.pop_front();
                    if (mon_e.is_read) chk("up_rdata", up_response_data, mon_e.data);
                end
            end
        end
    end

    // Memory model and downstream monitor; drives just after the clock edge.
    initial begin
        dn_ready = 1'b0;
        dn_response_data = '0;
        forever begin
            @(posedge clk);
            #1;
            dn_ready = 1'b0;
            if (!rstn || !dn_request) begin
                wait_cnt = 0;
            end else if (!mem_stall) begin
                if (wait_cnt >= mem_delay) begin
                    dn_ready = 1'b1;
                    dn_response_data = mem_rdata;
                    wait_cnt = 0;
                    if (!dn_write_enable) last_rd_cyc = cyc_n;
                    if (exp_dn_q.size() == 0) begin
                        total++;
                        $display("FAIL dn_unexpected: got addr 0x%0h we %0b required none",
                                 dn_address, dn_write_enable);
                    end else begin
                        mem_e = exp_dn_q.pop_front();
                        chk("dn_we", dn_write_enable, mem_e.we);
                        chk("dn_addr", dn_address, mem_e.addr);
                        if (mem_e.we) chk("dn_wdata", dn_write_data, mem_e.data);
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        up_request = 1'b0;
        up_write_enable = 1'b0;
        up_address = '0;
        up_write_data = '0;
        mem_stall = 1'b0;
        mem_delay = 5;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_wb_empty", wb_empty, 1);
        chk("rst_wb_count", wb_count, 0);
        chk("rst_wb_full", wb_full, 0);
        chk("rst_up_ready", up_ready, 0);
        chk("rst_dn_request", dn_request, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Single write, slow memory
        exp_dn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        up_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, lat);
        chk("t1_lat", lat, 1);
        chk("t1_count1", wb_count, 1);
        @(negedge clk);
        chk("t1_dn_req", dn_request, 1);
        chk("t1_dn_we", dn_write_enable, 1);
        wait_empty("t1_count0");

        // Fill to full, fifth write blocks until the first pop
        mem_stall = 1'b1;
        mem_delay = 3;
        for (int i = 0; i < 4; i++) begin
            exp_dn(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1));
            up_txn(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 32'h0, lat);
            chk("t2_lat", lat, 1);
        end
        chk("t2_full", wb_full, 1);
        chk("t2_count4", wb_count, 4);
        exp_dn(1'b1, 32'h110, 32'h5);
        p0 = up_pulses;
        fork
            up_txn(1'b1, 32'h110, 32'h5, 32'h0, lat5);
            begin
                repeat (4) @(negedge clk);
                chk("t2_blocked", up_pulses - p0, 0);
                chk("t2_still_full", wb_full, 1);
                mem_stall = 1'b0;
                wait_n = 0;
                while (!dn_ready && wait_n < 50) begin
                    @(negedge clk);
                    wait_n++;
                end
                pop_cyc = cyc_n;
            end
        join
        chk("t2_accept_after_pop", last_up_cyc - pop_cyc, 2);
        wait_empty("t2_empty");

        // Read hit forwarded from a buffered write
        mem_stall = 1'b1;
        mem_delay = 2;
        exp_dn(1'b1, 32'h2000, 32'h1111_1111);
        up_txn(1'b1, 32'h2000, 32'h1111_1111, 32'h0, lat);
        chk("t3_wr_lat", lat, 1);
        up_txn(1'b0, 32'h2000, 32'h0, 32'h1111_1111, lat);
        chk("t3_rd_lat", lat, 1);
        chk("t3_dn_is_write", dn_write_enable, 1);
        mem_stall = 1'b0;
        wait_empty("t3_empty");

        // Read miss takes priority over the second drain
        mem_stall = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        exp_dn(1'b1, 32'h3100, 32'h1);
        exp_dn(1'b0, 32'h3000, 32'h0);
        exp_dn(1'b1, 32'h3104, 32'h2);
        up_txn(1'b1, 32'h3100, 32'h1, 32'h0, lat);
        up_txn(1'b1, 32'h3104, 32'h2, 32'h0, lat);
        chk("t4_count2", wb_count, 2);
        fork
            up_txn(1'b0, 32'h3000, 32'h0, 32'hCAFE_0001, lat);
            begin
                repeat (3) @(negedge clk);
                chk("t4_drain_first", dn_write_enable, 1);
                mem_stall = 1'b0;
            end
        join
        chk("t4_resp_after_dn", last_up_cyc - last_rd_cyc, 1);
        wait_empty("t4_empty");

        // Same-address writes behind a draining head
        mem_stall = 1'b1;
        exp_dn(1'b1, 32'h4100, 32'h5);
        up_txn(1'b1, 32'h4100, 32'h5, 32'h0, lat);
        up_txn(1'b1, 32'h4000, 32'hA, 32'h0, lat);
        up_txn(1'b1, 32'h4000, 32'hB, 32'h0, lat);
        chk("t5_lat", lat, 1);
`ifdef WB_COALESCE_EN
        chk("t5_count", wb_count, 2);
        exp_dn(1'b1, 32'h4000, 32'hB);
`else
        chk("t5_count", wb_count, 3);
        exp_dn(1'b1, 32'h4000, 32'hA);
        exp_dn(1'b1, 32'h4000, 32'hB);
`endif
        up_txn(1'b0, 32'h4000, 32'h0, 32'hB, lat);
        chk("t5_rd_lat", lat, 1);
        mem_stall = 1'b0;
        wait_empty("t5_empty");

        // Reset in the middle of a drain
        mem_stall = 1'b1;
        up_txn(1'b1, 32'h5000, 32'h77, 32'h0, lat);
        repeat (2) @(negedge clk);
        chk("t6_dn_req_before", dn_request, 1);
        rstn = 1'b0;
        #1;
        chk("t6_dn_drop", dn_request, 0);
        chk("t6_empty", wb_empty, 1);
        chk("t6_count", wb_count, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        mem_stall = 1'b0;
        exp_dn(1'b1, 32'h6000, 32'h99);
        up_txn(1'b1, 32'h6000, 32'h99, 32'h0, lat);
        chk("t6_post_lat", lat, 1);
        wait_empty("t6_post_empty");

        repeat (5) @(negedge clk);
        chk("up_queue_drained", exp_up_q.size(), 0);
        chk("dn_queue_drained", exp_dn_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
